// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on the operand side
// and on the result side, plus the status flags that travel with the result.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, a, b, f, out_ready,
    input  in_ready, out_valid, y, zero, ovf, err
  );

  modport slave (
    input  in_valid, a, b, f, out_ready,
    output in_ready, out_valid, y, zero, ovf, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered MIPS-style ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to build the multicycle shift-add MUL/MULHU unit.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
`else
  typedef enum logic {ST_IDLE, ST_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             in_ready;
  logic             accept;
  logic             is_mul;

  logic [WIDTH-1:0] op_b, sum, diff, alu_y;
  logic [SHW-1:0]   shamt;
  logic             alu_ovf, alu_err, lt_s, lt_u;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mul_y;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               hi_q, hi_d;

  assign is_mul = (bus.f[3:1] == 3'b110);
`else
  assign is_mul = 1'b0;
`endif

  assign in_ready      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

  always_comb begin
    op_b    = bus.f[2] ? ~bus.b : bus.b;
    sum     = bus.a + op_b + {{(WIDTH-1){1'b0}}, bus.f[2]};
    diff    = bus.a - bus.b;
    // Signed less-than stays correct when a-b overflows
    lt_s    = diff[WIDTH-1] ^ ((bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (diff[WIDTH-1] != bus.a[WIDTH-1]));
    lt_u    = (bus.a < bus.b);
    shamt   = bus.b[SHW-1:0];
    alu_y   = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (bus.f)
      4'b0000: alu_y = bus.a & bus.b;
      4'b0001: alu_y = bus.a | bus.b;
      4'b0100: alu_y = bus.a & ~bus.b;
      4'b0101: alu_y = bus.a | ~bus.b;
      4'b0010, 4'b0110: begin
        alu_y   = sum;
        alu_ovf = (bus.a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0011, 4'b0111: alu_y = {{(WIDTH-1){1'b0}}, lt_s};
      4'b1000: alu_y = bus.a << shamt;
      4'b1001: alu_y = bus.a >> shamt;
      4'b1010: alu_y = $signed(bus.a) >>> shamt;
      4'b1011: alu_y = {{(WIDTH-1){1'b0}}, lt_u};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_y    = hi_q ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
`endif
    case (state_q)
`ifdef ALU_SEQ_MUL_EN
      // Multiplicand is pre-shifted each cycle rather than shifted by the counter
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          y_d     = mul_y;
          zero_d  = (mul_y == '0);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
`endif
      default: begin
        if (accept && !is_mul) begin
          y_d     = alu_y;
          zero_d  = (alu_y == '0);
          ovf_d   = alu_ovf;
          err_d   = alu_err;
          state_d = ST_DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          hi_d     = bus.f[0];
          state_d  = ST_MUL;
        end
`endif
        else if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      y_q      <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: accepted operations push an expected result,
// a negedge monitor checks handshake timing and pops on each delivered result.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         zero;
    logic         ovf;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   rand_or     = 1'b0;
  bit   exp_ov;
  exp_t ent;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode meanings
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    exp_t        e;
    longint      r;
    logic [63:0] p;
    logic [4:0]  sh;
    sh    = b[4:0];
    e.y   = '0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (f)
      4'h0: e.y = a & b;
      4'h1: e.y = a | b;
      4'h2: begin
        r     = longint'($signed(a)) + longint'($signed(b));
        e.y   = r[31:0];
        e.ovf = (r != longint'($signed(e.y)));
      end
      4'h6: begin
        r     = longint'($signed(a)) - longint'($signed(b));
        e.y   = r[31:0];
        e.ovf = (r != longint'($signed(e.y)));
      end
      4'h3, 4'h7: e.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h4: e.y = a & ~b;
      4'h5: e.y = a | ~b;
      4'h8: e.y = a << sh;
      4'h9: e.y = a >> sh;
      4'hA: e.y = $signed(a) >>> sh;
      4'hB: e.y = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
      4'hC, 4'hD: begin
        p     = {32'h0, a} * {32'h0, b};
        e.y   = f[0] ? p[63:32] : p[31:0];
        e.lat = W + 1;
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.zero = (e.y == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
      chkb("out_valid", bus.out_valid, exp_ov);
      chkb("in_ready", bus.in_ready, (q.size() == 0) || (exp_ov && bus.out_ready));
      if (exp_ov && bus.out_valid) begin
        chk("y", bus.y, q[0].y);
        chkb("zero", bus.zero, q[0].zero);
        chkb("ovf", bus.ovf, q[0].ovf);
        chkb("err", bus.err, q[0].err);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        ent     = model(bus.a, bus.b, bus.f);
        ent.acc = cyc;
        q.push_back(ent);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_or) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  // Called just after a posedge; returns just after the accepting posedge
  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [3:0] ff);
    bit got;
    got          = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = aa;
    bus.b        = bb;
    bus.f        = ff;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.f        = 4'($urandom_range(0, 15));
    chkb("accept_timeout", got, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.f         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk ("rst_y", bus.y, 32'h0);
    chkb("rst_out_valid", bus.out_valid, 1'b0);
    chkb("rst_zero", bus.zero, 1'b0);
    chkb("rst_ovf", bus.ovf, 1'b0);
    chkb("rst_err", bus.err, 1'b0);
    chkb("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Reset while an operation is in flight (mid-MUL when the multiplier is built)
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100);
    idle(4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    chk ("rst2_y", bus.y, 32'h0);
    chkb("rst2_out_valid", bus.out_valid, 1'b0);
    chkb("rst2_err", bus.err, 1'b0);
    chkb("rst2_zero", bus.zero, 1'b0);
    chkb("rst2_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    bus.out_ready = 1'b1;
    do_op(32'd3,         32'd4,         4'b0010);
    do_op(32'h7FFF_FFFF, 32'd1,         4'b0010);
    do_op(32'd5,         32'd5,         4'b0110);
    do_op(32'h8000_0000, 32'd1,         4'b0011);
    do_op(32'h8000_0000, 32'd1,         4'b1011);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0111);
    do_op(32'h8000_0000, 32'd31,        4'b1010);
    do_op(32'h8000_0000, 32'd31,        4'b1001);
    do_op(32'd1,         32'h21,        4'b1000);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b1110);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b1111);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0100);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0101);
    idle(2);

    // Backpressure: result held for 4 cycles, then released with a new op waiting
    bus.out_ready = 1'b0;
    do_op(32'h0000_00FF, 32'h0000_0F0F, 4'b0000);
    idle(4);
    bus.out_ready = 1'b1;
    do_op(32'd100, 32'd58, 4'b0110);
    do_op(32'd9,   32'd2,  4'b0001);
    idle(2);

    rand_or = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      do_op(rnd_opnd(), rnd_opnd(), 4'($urandom_range(0, 15)));
    end
    rand_or = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    chkb("drain_empty", (q.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational MIPS ALU.
- Keeps the AND/OR/ADD/SUB/SLT function set with the f[2] invert-b encoding and adds shifts, unsigned compare, signed overflow and a multicycle shift-add multiplier.
- Sits between the datapath operand registers and the writeback stage.
- Uses a valid/ready handshake on both the operand side and the result side, so multicycle operations can stall the pipeline.

Parameters:
- WIDTH, 32, operand and result width in bits; must be 8 or greater and a power of two.
- SHW, $clog2(WIDTH), number of b LSBs used as the shift amount (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- f  in  4  opcode.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- y  out  WIDTH  result.
- zero  out  1  high when y == 0.
- ovf  out  1  signed overflow (ADD/SUB only).
- err  out  1  illegal or disabled opcode.

Behaviour:
- Opcode map:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLT (signed).
  - 0100 a&~b, 0101 a|~b, 0110 SUB (a+~b+1), 0111 SLT (signed; identical to 0011).
  - 1000 SLL, 1001 SRL, 1010 SRA; shift amount is b[SHW-1:0].
  - 1011 SLTU.
  - 1100 MUL (low WIDTH bits of a*b, unsigned), 1101 MULHU (high WIDTH bits).
  - 1110 and 1111 are illegal.
- SLT/SLTU result: y = {WIDTH-1 zeros, lt}.
- Signed SLT must be correct under overflow: lt = sign(a-b) XOR ovf_sub.
- ovf = (a[W-1]==op_b[W-1]) && (sum[W-1]!=a[W-1]), where op_b is b for ADD and ~b for SUB. ovf = 0 for all other ops.
- Carry-out is discarded.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready.
  - Single-cycle op (anything except 1100/1101): on accept, register y/zero/ovf/err and go to DONE. out_valid rises the next cycle (latency 1).
  - Illegal op: on accept, y=0, zero=1, err=1, then DONE.
  - MUL/MULHU: on accept, load the multiplicand, multiplier and a 2*WIDTH accumulator=0, set counter=0, go to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand (shifted by counter) to the accumulator; shift the multiplier right; counter++.
  - After WIDTH iterations, register the selected half into y and go to DONE.
  - Accept at cycle 0 gives out_valid at cycle WIDTH+1.
  - DONE: out_valid=1 and y/zero/ovf/err are held stable until out_ready. With out_ready high and no new accept, go to IDLE. Back-to-back accept in the same cycle follows the single-cycle / MUL rules above.
  - IDLE and MUL: out_valid=0; in_ready=0 throughout MUL.
- Outputs only change on an accept-driven update. Operand inputs are don't-care when not accepted.
- Reset (any state, including mid-MUL):
  - Abort the operation and go to IDLE.
  - out_valid=0, y=0, zero=0, ovf=0, err=0.
  - Accumulator and counter cleared.
  - in_ready=1 in the cycle after reset deasserts.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL/MULHU behave as specified above, including the MUL state and counter.
- Undefined:
  - No multiplier logic and no MUL state are built.
  - Opcodes 1100/1101 are treated as illegal: latency 1, y=0, zero=1, err=1.

Test Plan:
- Reset mid-MUL at cycle 5, WIDTH=32 -> next cycle out_valid=0, y=0, in_ready=1; a following ADD 3+4 returns y=7, out_valid one cycle after accept.
- ADD 0x7FFFFFFF+1 -> y=0x80000000, ovf=1, zero=0. SUB 5-5 -> y=0, zero=1, ovf=0.
- SLT a=0x80000000 b=0x00000001 -> y=1. SLTU with the same operands -> y=0. SLT a=0x7FFFFFFF b=0xFFFFFFFF -> y=0.
- SRA a=0x80000000 b=31 -> y=0xFFFFFFFF. SRL with the same operands -> y=1. SLL a=1 b=0x21 -> y=2 (b[4:0]=1).
- With ALU_SEQ_MUL_EN:
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> out_valid at cycle 33, y=0x00000001.
  - MULHU with the same operands -> y=0xFFFFFFFE.
  - in_ready=0 during cycles 1-32.
- Without the macro: MUL -> y=0, err=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 4 cycles with a result pending -> y stable, in_ready=0. Then out_ready=1 with in_valid=1 -> next op accepted the same cycle, no result lost or duplicated.
- Opcode 1110 -> y=0, zero=1, err=1.
